// File: rtl/dice_game_pkg.sv
// Shared types for the dice race game: detector colour codes, the turn
// scheduler state encoding and the colour-to-step conversion.
package dice_game_pkg;

   // Colour codes as produced by the colour result manager
   typedef enum logic [1:0] {
      COLOR_NONE  = 2'b00,
      COLOR_RED   = 2'b01,
      COLOR_GREEN = 2'b10,
      COLOR_BLUE  = 2'b11
   } color_t;

   // Turn scheduler states; the encoding is exported on state_dbg
   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_WHITE = 3'd1,
      ST_WAIT_COLOR = 3'd2,
      ST_APPLY      = 3'd3,
      ST_WAIT_CLEAR = 3'd4,
      ST_NEXT       = 3'd5,
      ST_DONE       = 3'd6
   } turn_state_t;

   // RED/GREEN/BLUE move one/two/three squares; NONE is never a move
   function automatic logic [1:0] color_to_steps(input color_t color);
      logic [1:0] steps;
      steps = 2'd0;
      case (color)
         COLOR_RED:   steps = 2'd1;
         COLOR_GREEN: steps = 2'd2;
         COLOR_BLUE:  steps = 2'd3;
         default:     steps = 2'd0;
      endcase
      return steps;
   endfunction

endpackage

// File: rtl/dice_turn_scheduler_timeout_counter.sv
// Frame counter that forfeits a turn after TIMEOUT_FRAMES camera frames.
// A value of zero for TIMEOUT_FRAMES disables the timeout entirely.
module turn_timeout_counter #(
   parameter int TIMEOUT_FRAMES = 300
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int CNT_W = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [CNT_W-1:0] LAST_COUNT =
      CNT_W'((TIMEOUT_FRAMES == 0) ? 0 : TIMEOUT_FRAMES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Expire on the frame tick that would bring the count up to the limit
   always_comb begin
      expire_o = (TIMEOUT_FRAMES != 0) && enable_i && (count_q == LAST_COUNT);
      count_d  = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expire_o) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Frame count register, cleared whenever no turn is waiting for a colour
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dice_turn_scheduler.sv
// Turn sequencer for the dice race game. Grants one player at a time,
// converts the confirmed dice colour into a move, saturates the position at
// the finish square and hands the turn on once the board is clear again.
module dice_turn_scheduler
   import dice_game_pkg::*;
#(
   parameter int NUM_PLAYERS    = 4,
   parameter int BOARD_LEN      = 30,
   parameter int TIMEOUT_FRAMES = 300,
   parameter int POS_W          = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         frame_tick,
   input  logic [1:0]                   stable_color,
   input  logic                         result_ready,
   input  logic                         turn_end,
   input  logic                         current_state_white,
   output logic [1:0]                   cur_player,
   output logic [NUM_PLAYERS*POS_W-1:0] player_pos,
   output logic                         move_valid,
   output logic [1:0]                   move_steps,
   output logic                         timeout_evt,
   output logic                         game_over,
   output logic [1:0]                   winner,
   output logic [2:0]                   state_dbg
);

   localparam logic [POS_W:0]   BOARD_LEN_W = (POS_W + 1)'(BOARD_LEN);
   localparam logic [POS_W-1:0] FINISH_POS  = POS_W'(BOARD_LEN);
   localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);

   turn_state_t      state_q,      state_d;
   logic [1:0]       curPlayer_q,  curPlayer_d;
   logic [POS_W-1:0] pos_q [NUM_PLAYERS];
   logic [POS_W-1:0] pos_d [NUM_PLAYERS];
   logic [1:0]       steps_q,      steps_d;
   logic             moveValid_q,  moveValid_d;
   logic [1:0]       moveSteps_q,  moveSteps_d;
   logic             timeoutEvt_q, timeoutEvt_d;
   logic             gameOver_q,   gameOver_d;
   logic [1:0]       winner_q,     winner_d;

   logic             timerExpire;
   logic [POS_W:0]   sumPos;
   logic [POS_W-1:0] newPos;
   color_t           color;

   assign color = color_t'(stable_color);

   turn_timeout_counter #(
      .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (state_q != ST_WAIT_COLOR),
      .enable_i ((state_q == ST_WAIT_COLOR) && frame_tick),
      .expire_o (timerExpire)
   );

   // Next state and next output values for the whole turn sequence
   always_comb begin
      state_d      = state_q;
      curPlayer_d  = curPlayer_q;
      pos_d        = pos_q;
      steps_d      = steps_q;
      moveValid_d  = 1'b0;
      moveSteps_d  = moveSteps_q;
      timeoutEvt_d = 1'b0;
      gameOver_d   = gameOver_q;
      winner_d     = winner_q;

      sumPos = {1'b0, pos_q[curPlayer_q]} + {{(POS_W-1){1'b0}}, steps_q};
      newPos = (sumPos >= BOARD_LEN_W) ? FINISH_POS : sumPos[POS_W-1:0];

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               pos_d       = '{default: '0};
               curPlayer_d = 2'd0;
               gameOver_d  = 1'b0;
               winner_d    = 2'd0;
               state_d     = ST_WAIT_WHITE;
            end
         end
         ST_WAIT_WHITE: begin
            if (current_state_white) begin
               state_d = ST_WAIT_COLOR;
            end
         end
         ST_WAIT_COLOR: begin
            if (result_ready && (color != COLOR_NONE)) begin
               steps_d = color_to_steps(color);
               state_d = ST_APPLY;
            end else if (timerExpire) begin
               timeoutEvt_d = 1'b1;
               state_d      = ST_NEXT;
            end
         end
         ST_APPLY: begin
            pos_d[curPlayer_q] = newPos;
            moveValid_d        = 1'b1;
            moveSteps_d        = steps_q;
            if (newPos == FINISH_POS) begin
               gameOver_d = 1'b1;
               winner_d   = curPlayer_q;
               state_d    = ST_DONE;
            end else begin
               state_d = ST_WAIT_CLEAR;
            end
         end
         ST_WAIT_CLEAR: begin
            if (turn_end) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            curPlayer_d = (curPlayer_q == LAST_PLAYER) ? 2'd0 : curPlayer_q + 2'd1;
            state_d     = ST_WAIT_WHITE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All scheduler state and every output is held in these registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         curPlayer_q  <= 2'd0;
         pos_q        <= '{default: '0};
         steps_q      <= 2'd0;
         moveValid_q  <= 1'b0;
         moveSteps_q  <= 2'd0;
         timeoutEvt_q <= 1'b0;
         gameOver_q   <= 1'b0;
         winner_q     <= 2'd0;
      end else begin
         state_q      <= state_d;
         curPlayer_q  <= curPlayer_d;
         pos_q        <= pos_d;
         steps_q      <= steps_d;
         moveValid_q  <= moveValid_d;
         moveSteps_q  <= moveSteps_d;
         timeoutEvt_q <= timeoutEvt_d;
         gameOver_q   <= gameOver_d;
         winner_q     <= winner_d;
      end
   end

   // Pack the per-player position registers onto the output bus
   always_comb begin
      player_pos = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         player_pos[i*POS_W +: POS_W] = pos_q[i];
      end
   end

   assign cur_player  = curPlayer_q;
   assign move_valid  = moveValid_q;
   assign move_steps  = moveSteps_q;
   assign timeout_evt = timeoutEvt_q;
   assign game_over   = gameOver_q;
   assign winner      = winner_q;
   assign state_dbg   = state_q;

endmodule
